deskew: RTL and testbench
=========================

Name: deskew

Overview:
- Receive-side counterpart of the team's skewing delay line.
- Lane i of an array output arrives i cycles after lane 0 (staggered, systolic style). This block re-aligns the lanes into one word and buffers aligned words in a small first-word-fall-through (FWFT) FIFO with a valid/ready output.
- Flags misaligned vectors and FIFO overflow.

Parameters:
- data_size, 16, bits per lane
- size, 4, number of lanes (>=1)
- fifo_depth, 4, aligned-word FIFO entries (power of 2, >=2)

Ports:
- clk  input  1  clock, all logic on rising edge
- rst_n  input  1  synchronous active-low reset
- bus_in  input  data_size*size  lane i = bits [data_size*(i+1)-1 : data_size*i]
- valid_in  input  size  per-lane valid, bit i qualifies lane i
- bus_out  output  data_size*size  aligned word at FIFO head
- valid_out  output  1  FIFO non-empty
- ready_out  input  1  consumer accepts bus_out when valid_out & ready_out at an edge
- count  output  $clog2(fifo_depth+1)  FIFO occupancy
- misalign  output  1  sticky: partial aligned vector seen
- overflow  output  1  sticky: aligned word dropped because FIFO full
- clear  input  1  clears misalign and overflow

Behaviour:
- Reset (rst_n=0 at an edge):
  - all delay-chain data and valid bits go to 0; FIFO pointers and count go to 0.
  - valid_out=0, bus_out=0, misalign=0, overflow=0.
  - Any partially received vector is discarded.
- Alignment:
  - lane i (data and valid) passes through size-1-i register stages.
  - Lane size-1 has zero stages and is used directly.
  - The aligned view at edge E is lane i as sampled at edge E-(size-1-i).
  - size=1: no delay stages.
- Push:
  - at edge E, the aligned word is written to the FIFO iff all aligned valid bits are 1.
  - Latency: a vector whose lane 0 is sampled at edge E0 (lane i at E0+i) is written at edge E0+size-1.
  - valid_out is high in the following cycle; the earliest transfer is edge E0+size.
- Misalign: if the aligned valid bits are neither all 0 nor all 1 at an edge, there is no push, the word is discarded, and misalign is set to 1.
- FIFO:
  - pop occurs when valid_out & ready_out at an edge.
  - bus_out = head entry when valid_out=1, else 0. It is combinational from storage; no extra cycle.
  - Push and pop at the same edge: both happen and count is unchanged. This also holds when full, with no overflow.
  - Push when full with no pop: word dropped, overflow set to 1, FIFO contents unchanged.
  - Pop when empty cannot occur (valid_out=0).
  - Pointers wrap modulo fifo_depth; count ranges 0..fifo_depth.
  - Order is strictly FIFO.
- Sticky flags:
  - clear=1 at an edge sets the flag to 0, unless a new setting event occurs at the same edge; the event wins and the flag stays 1.
  - Reset overrides everything.
- No backpressure on the input side: valid_in is never stalled. The consumer or software must honour overflow.

Test Plan (data_size=16, size=4, fifo_depth=4):
1. Skewed single vector: lane i valid only at edge i, data 0x1000+i, ready_out=1.
   -> valid_out=1 for exactly one cycle after edge 3.
   -> bus_out=0x1003_1002_1001_1000.
   -> count 0->1->0; no flags.
2. Streaming: 8 vectors back-to-back (lane 0 of vector k at edge k, data 0x2k0i), ready_out=1.
   -> 8 consecutive valid_out cycles starting after edge 3, words in order, count never exceeds 1.
3. Overflow: ready_out=0, 5 vectors streamed.
   -> count=4, overflow=1 after the 5th push edge.
   -> then ready_out=1 drains vectors 1-4 in order; vector 5 is never output.
4. Misalign: vector with lane 2 valid withheld.
   -> no push, count=0, misalign=1.
   -> clear pulse -> misalign=0 next cycle.
   -> clear coinciding with a new misalign edge -> misalign stays 1.
5. Full with simultaneous push and pop: FIFO full, ready_out=1 on the same edge an aligned push occurs.
   -> count stays 4, overflow stays 0, the popped word is the oldest one.
6. Reset mid-stream: rst_n=0 for one edge after lanes 0-1 of a vector are sampled, remaining lanes still driven.
   -> after release: valid_out=0, bus_out=0, count=0, no push from the partial vector, misalign set only by lanes sampled after reset.

Source files
------------

// File: rtl/deskew_if.sv
// Bus bundle for the deskew block: lane-staggered input side and aligned FWFT output side.
interface deskew_if #(
  parameter int data_size  = 16,
  parameter int size       = 4,
  parameter int fifo_depth = 4
);
  localparam int CW = $clog2(fifo_depth + 1);

  logic [data_size*size-1:0] bus_in;
  logic [size-1:0]           valid_in;
  logic [data_size*size-1:0] bus_out;
  logic                      valid_out;
  logic                      ready_out;
  logic [CW-1:0]             count;
  logic                      misalign;
  logic                      overflow;
  logic                      clear;

  modport master (
    output bus_in, valid_in, ready_out, clear,
    input  bus_out, valid_out, count, misalign, overflow
  );

  modport slave (
    input  bus_in, valid_in, ready_out, clear,
    output bus_out, valid_out, count, misalign, overflow
  );
endinterface

// File: rtl/deskew.sv
// Re-aligns lane-staggered vectors into whole words and queues them in a small FWFT FIFO,
// with sticky flags for partial vectors and for words dropped on a full FIFO.
module deskew #(
  parameter int data_size  = 16,
  parameter int size       = 4,
  parameter int fifo_depth = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  deskew_if.slave bus
);
  localparam int W  = data_size * size;
  localparam int LW = data_size + 1;
  localparam int AW = $clog2(fifo_depth);
  localparam int CW = $clog2(fifo_depth + 1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(fifo_depth);

  logic [W-1:0]    al_data_s;
  logic [size-1:0] al_valid_s;

  // Lane i waits size-1-i cycles so every lane of a vector lines up with the last lane.
  for (genvar i = 0; i < size; i++) begin : g_lane
    localparam int NS = size - 1 - i;
    if (NS == 0) begin : g_direct
      assign al_valid_s[i]                      = bus.valid_in[i];
      assign al_data_s[data_size*i +: data_size] = bus.bus_in[data_size*i +: data_size];
    end else begin : g_pipe
      logic [LW-1:0] pipe_q [NS];

      // Shift register for this lane; entry NS-1 holds the oldest sample.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int k = 0; k < NS; k++) pipe_q[k] <= {LW{1'b0}};
        end else begin
          pipe_q[0] <= {bus.valid_in[i], bus.bus_in[data_size*i +: data_size]};
          for (int k = 1; k < NS; k++) pipe_q[k] <= pipe_q[k-1];
        end
      end

      assign al_valid_s[i]                      = pipe_q[NS-1][LW-1];
      assign al_data_s[data_size*i +: data_size] = pipe_q[NS-1][data_size-1:0];
    end
  end

  logic [W-1:0]  mem_q [fifo_depth];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          misalign_q, misalign_d;
  logic          overflow_q, overflow_d;
  logic          all_v_s, mis_evt_s, full_s, valid_s, pop_s, push_s, drop_s;

  // Push/pop decisions and next-state for pointers, occupancy and sticky flags.
  always_comb begin
    all_v_s   = &al_valid_s;
    mis_evt_s = (|al_valid_s) && !all_v_s;
    full_s    = (count_q == CNT_FULL);
    valid_s   = (count_q != {CW{1'b0}});
    pop_s     = valid_s && bus.ready_out;
    // A simultaneous pop frees the slot, so a full FIFO still accepts the push.
    push_s    = all_v_s && (!full_s || pop_s);
    drop_s    = all_v_s && full_s && !pop_s;

    wr_ptr_d = push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = pop_s  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    if (mis_evt_s) begin
      misalign_d = 1'b1;
    end else if (bus.clear) begin
      misalign_d = 1'b0;
    end else begin
      misalign_d = misalign_q;
    end

    if (drop_s) begin
      overflow_d = 1'b1;
    end else if (bus.clear) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // FIFO control and flag registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= {AW{1'b0}};
      rd_ptr_q   <= {AW{1'b0}};
      count_q    <= {CW{1'b0}};
      misalign_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      misalign_q <= misalign_d;
      overflow_q <= overflow_d;
    end
  end

  // FIFO storage; cleared on reset so no stale word can ever surface.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < fifo_depth; k++) mem_q[k] <= {W{1'b0}};
    end else if (push_s) begin
      mem_q[wr_ptr_q] <= al_data_s;
    end
  end

  assign bus.bus_out   = valid_s ? mem_q[rd_ptr_q] : {W{1'b0}};
  assign bus.valid_out = valid_s;
  assign bus.count     = count_q;
  assign bus.misalign  = misalign_q;
  assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_deskew.sv
// Self-checking bench for deskew: table-driven steps, hand-written misalign/reset sequences,
// and a scoreboard queue matched against every word the consumer accepts.
module tb_deskew;
  localparam int DS = 16;
  localparam int SZ = 4;
  localparam int FD = 4;

  typedef struct {
    logic [3:0]  mask;
    logic [15:0] base;
    bit          keep;
  } vec_t;

  typedef struct {
    vec_t  v;
    logic  rdy;
    logic  clr;
    int    exp_cnt;
    logic  exp_ovf;
    logic  exp_mis;
    string name;
  } step_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  deskew_if #(.data_size(DS), .size(SZ), .fifo_depth(FD)) bus ();

  deskew #(.data_size(DS), .size(SZ), .fifo_depth(FD)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int          total = 0;
  int          bad = 0;
  logic [63:0] exp_q[$];
  vec_t        slot[SZ];
  bit          mon_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t vv(input logic [3:0] m, input logic [15:0] b, input bit k);
    vec_t r;
    r.mask = m;
    r.base = b;
    r.keep = k;
    return r;
  endfunction

  function automatic step_t st(input vec_t v, input logic rdy, input logic clr, input int c,
                               input logic o, input logic m, input string n);
    step_t r;
    r.v = v; r.rdy = rdy; r.clr = clr; r.exp_cnt = c;
    r.exp_ovf = o; r.exp_mis = m; r.name = n;
    return r;
  endfunction

  // Starts vector v this cycle (lane 0 now, lane i i cycles later) and advances one edge.
  task automatic cycle(input vec_t v);
    for (int i = SZ - 1; i > 0; i--) slot[i] = slot[i-1];
    slot[0] = v;
    for (int i = 0; i < SZ; i++) begin
      bus.valid_in[i]        = slot[i].mask[i];
      bus.bus_in[DS*i +: DS] = slot[i].base + 16'(i);
    end
    if (v.keep && v.mask == 4'hF)
      exp_q.push_back({v.base + 16'd3, v.base + 16'd2, v.base + 16'd1, v.base});
    @(posedge clk);
    #1;
  endtask

  // Every accepted word must be the oldest outstanding expectation.
  always @(negedge clk) begin
    if (mon_en && bus.valid_out === 1'b1 && bus.ready_out === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_word: got %0h expected none", bus.bus_out);
      end else begin
        chk("word_order", bus.bus_out, exp_q.pop_front());
      end
    end
  end

  initial begin
    step_t tbl[$];
    vec_t  e;
    vec_t  mis;
    e   = vv(4'h0, 16'h0000, 1'b0);
    mis = vv(4'b1011, 16'h4000, 1'b0);
    for (int i = 0; i < SZ; i++) slot[i] = e;

    // Skewed single vector.
    tbl.push_back(st(vv(4'hF, 16'h1000, 1'b1), 1'b1, 1'b0, 0, 1'b0, 1'b0, "single"));
    tbl.push_back(st(e, 1'b1, 1'b0, 0, 1'b0, 1'b0, "single"));
    tbl.push_back(st(e, 1'b1, 1'b0, 0, 1'b0, 1'b0, "single"));
    tbl.push_back(st(e, 1'b1, 1'b0, 1, 1'b0, 1'b0, "single"));
    tbl.push_back(st(e, 1'b1, 1'b0, 0, 1'b0, 1'b0, "single"));
    // Streaming, ready always high.
    for (int k = 0; k < 8; k++)
      tbl.push_back(st(vv(4'hF, 16'h2000 + 16'(k << 8), 1'b1), 1'b1, 1'b0,
                       (k >= 3) ? 1 : 0, 1'b0, 1'b0, "stream"));
    for (int k = 0; k < 4; k++)
      tbl.push_back(st(e, 1'b1, 1'b0, (k < 3) ? 1 : 0, 1'b0, 1'b0, "stream"));
    // Overflow: five vectors into a stalled four-entry FIFO, then drain and clear.
    for (int k = 0; k < 5; k++)
      tbl.push_back(st(vv(4'hF, 16'h3000 + 16'(k << 8), k < 4), 1'b0, 1'b0,
                       (k == 3) ? 1 : ((k == 4) ? 2 : 0), 1'b0, 1'b0, "ovf"));
    tbl.push_back(st(e, 1'b0, 1'b0, 3, 1'b0, 1'b0, "ovf"));
    tbl.push_back(st(e, 1'b0, 1'b0, 4, 1'b0, 1'b0, "ovf"));
    tbl.push_back(st(e, 1'b0, 1'b0, 4, 1'b1, 1'b0, "ovf"));
    for (int k = 0; k < 4; k++)
      tbl.push_back(st(e, 1'b1, 1'b0, 3 - k, 1'b1, 1'b0, "ovf_drain"));
    tbl.push_back(st(e, 1'b1, 1'b1, 0, 1'b0, 1'b0, "ovf_clear"));
    // Full FIFO with push and pop on the same edge.
    for (int k = 0; k < 5; k++)
      tbl.push_back(st(vv(4'hF, 16'h5000 + 16'(k << 8), 1'b1), 1'b0, 1'b0,
                       (k == 3) ? 1 : ((k == 4) ? 2 : 0), 1'b0, 1'b0, "full_pp"));
    tbl.push_back(st(e, 1'b0, 1'b0, 3, 1'b0, 1'b0, "full_pp"));
    tbl.push_back(st(e, 1'b0, 1'b0, 4, 1'b0, 1'b0, "full_pp"));
    tbl.push_back(st(e, 1'b1, 1'b0, 4, 1'b0, 1'b0, "full_pp_edge"));
    for (int k = 0; k < 4; k++)
      tbl.push_back(st(e, 1'b1, 1'b0, 3 - k, 1'b0, 1'b0, "full_pp_drain"));

    // Reset state.
    bus.ready_out = 1'b1;
    bus.clear     = 1'b0;
    rst_n         = 1'b0;
    cycle(e);
    cycle(e);
    chk("rst_valid", 64'(bus.valid_out), 64'd0);
    chk("rst_bus", 64'(bus.bus_out), 64'd0);
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_mis", 64'(bus.misalign), 64'd0);
    chk("rst_ovf", 64'(bus.overflow), 64'd0);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    foreach (tbl[n]) begin
      bus.ready_out = tbl[n].rdy;
      bus.clear     = tbl[n].clr;
      cycle(tbl[n].v);
      chk({tbl[n].name, "_count"}, 64'(bus.count), 64'(tbl[n].exp_cnt));
      chk({tbl[n].name, "_valid"}, 64'(bus.valid_out), 64'(tbl[n].exp_cnt != 0));
      chk({tbl[n].name, "_ovf"}, 64'(bus.overflow), 64'(tbl[n].exp_ovf));
      chk({tbl[n].name, "_mis"}, 64'(bus.misalign), 64'(tbl[n].exp_mis));
      if (tbl[n].exp_cnt == 0) chk({tbl[n].name, "_bus_idle"}, 64'(bus.bus_out), 64'd0);
    end
    bus.ready_out = 1'b1;
    bus.clear     = 1'b0;

    // Misalign: lane 2 withheld, then clear, then clear colliding with a new event.
    cycle(mis);
    cycle(e);
    cycle(e);
    chk("mis_before", 64'(bus.misalign), 64'd0);
    cycle(e);
    chk("mis_set", 64'(bus.misalign), 64'd1);
    chk("mis_count", 64'(bus.count), 64'd0);
    chk("mis_valid", 64'(bus.valid_out), 64'd0);
    bus.clear = 1'b1;
    cycle(e);
    bus.clear = 1'b0;
    chk("mis_clear", 64'(bus.misalign), 64'd0);
    cycle(mis);
    cycle(e);
    cycle(e);
    chk("mis_still_clear", 64'(bus.misalign), 64'd0);
    bus.clear = 1'b1;
    cycle(e);
    bus.clear = 1'b0;
    chk("mis_clear_collision", 64'(bus.misalign), 64'd1);
    bus.clear = 1'b1;
    cycle(e);
    bus.clear = 1'b0;
    chk("mis_clear2", 64'(bus.misalign), 64'd0);

    // Reset after lanes 0-1 of a vector; lanes 2-3 still arrive.
    cycle(e);
    cycle(vv(4'hF, 16'h6000, 1'b0));
    cycle(e);
    rst_n = 1'b0;
    cycle(e);
    rst_n = 1'b1;
    chk("mid_rst_valid", 64'(bus.valid_out), 64'd0);
    chk("mid_rst_bus", 64'(bus.bus_out), 64'd0);
    chk("mid_rst_count", 64'(bus.count), 64'd0);
    chk("mid_rst_mis", 64'(bus.misalign), 64'd0);
    cycle(e);
    chk("post_rst_mis", 64'(bus.misalign), 64'd1);
    chk("post_rst_count", 64'(bus.count), 64'd0);
    for (int k = 0; k < 3; k++) begin
      cycle(e);
      chk("post_rst_idle", 64'(bus.valid_out), 64'd0);
    end

    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
